// File: rtl/link_downstream_sipo.sv
// Receive-side SIPO: gathers NUM_CH channel beats per io cycle into CORE_WIDTH words, buffers them, hands them to the core.
// Latency: last beat in cycle t -> core_valid_o with that word in t+1; pop in t -> next head in t+1; token toggle 1 cycle after the TOKEN_DIV-th yumi.
// Backpressure: no ready toward the link; upstream credit (io_token_o toggles) bounds words in flight. A push into a full FIFO without a pop drops the word. Optional LINK_DS_OVERFLOW_CHECK_EN adds a sticky overflow_o and assertions.
module link_downstream_sipo #(
    parameter int CH_WIDTH   = 8,
    parameter int NUM_CH     = 2,
    parameter int CORE_WIDTH = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int TOKEN_DIV  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  io_valid_i,
    input  logic [CH_WIDTH-1:0]   io_data_ch0_i,
    input  logic [CH_WIDTH-1:0]   io_data_ch1_i,
    output logic                  io_token_o,
    output logic                  core_valid_o,
    output logic [CORE_WIDTH-1:0] core_data_o,
    input  logic                  core_yumi_i,
    output logic                  overflow_o
);

    // Two physical channel ports exist, so a beat is always {ch1, ch0}.
    localparam int BEAT_W = CH_WIDTH * NUM_CH;
    localparam int BEATS  = CORE_WIDTH / BEAT_W;
    localparam int BC_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int TOK_W  = (TOKEN_DIV > 1) ? $clog2(TOKEN_DIV) : 1;

    logic [BEAT_W-1:0]     beat_dat;
    logic [BC_W-1:0]       beat_ctr;
    logic [CORE_WIDTH-1:0] asm_q;
    logic [CORE_WIDTH-1:0] asm_d;
    logic                  beat_last;

    logic [CORE_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  push_ok;
    logic                  drop;

    logic [TOK_W-1:0]      tok_ctr;
    logic                  tok_q;

    assign beat_dat = {io_data_ch1_i, io_data_ch0_i};

    // Merge the incoming beat into its slot; beat 0 occupies the lowest bits.
    always_comb begin
        asm_d = asm_q;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_ctr == BC_W'(k)) begin
                asm_d[k*BEAT_W +: BEAT_W] = beat_dat;
            end
        end
    end

    assign beat_last = io_valid_i && (beat_ctr == BC_W'(BEATS - 1));

    // A pop only counts when there is a head word; a stray yumi is ignored.
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign push    = beat_last;
    assign pop     = core_yumi_i && (count != '0);
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    // Beat counter and partial word; idle cycles hold both so gaps never abort a word.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_ctr <= '0;
            asm_q    <= '0;
        end else if (io_valid_i) begin
            asm_q    <= asm_d;
            beat_ctr <= beat_last ? '0 : beat_ctr + 1'b1;
        end
    end

    // Word storage; the completed word (including the final beat) is written directly.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= asm_d;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Credit return: one token-line toggle per TOKEN_DIV consumed words.
    always_ff @(posedge clk) begin
        if (rst) begin
            tok_ctr <= '0;
            tok_q   <= 1'b0;
        end else if (pop) begin
            if (tok_ctr == TOK_W'(TOKEN_DIV - 1)) begin
                tok_ctr <= '0;
                tok_q   <= ~tok_q;
            end else begin
                tok_ctr <= tok_ctr + 1'b1;
            end
        end
    end

    assign io_token_o   = tok_q;
    assign core_valid_o = (count != '0);
    assign core_data_o  = mem[rd_ptr];

`ifdef LINK_DS_OVERFLOW_CHECK_EN
    logic ovf_q;

    // Sticky record of any dropped word; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow_o = ovf_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !drop);
    a_yumi_needs_valid: assert property (@(posedge clk) disable iff (rst) !(core_yumi_i && !core_valid_o));
`else
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_link_downstream_sipo.sv
// Directed bench for link_downstream_sipo: assembly, gaps, fill/drain, full push+pop, drop, stray yumi, reset mid-word, streaming.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same offset.
// Each test task performs its own comparisons and bumps total/bad.
module tb_link_downstream_sipo;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_valid_i;
    logic [7:0]  io_data_ch0_i;
    logic [7:0]  io_data_ch1_i;
    logic        io_token_o;
    logic        core_valid_o;
    logic [63:0] core_data_o;
    logic        core_yumi_i;
    logic        overflow_o;

    int total = 0;
    int bad   = 0;

    logic [63:0] wv [5];

`ifdef LINK_DS_OVERFLOW_CHECK_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    link_downstream_sipo dut (
        .clk           (clk),
        .rst           (rst),
        .io_valid_i    (io_valid_i),
        .io_data_ch0_i (io_data_ch0_i),
        .io_data_ch1_i (io_data_ch1_i),
        .io_token_o    (io_token_o),
        .core_valid_o  (core_valid_o),
        .core_data_o   (core_data_o),
        .core_yumi_i   (core_yumi_i),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        io_valid_i = 1'b0;
        core_yumi_i = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] c0, input logic [7:0] c1);
        io_valid_i    = 1'b1;
        io_data_ch0_i = c0;
        io_data_ch1_i = c1;
        tick();
        io_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w);
        for (int k = 0; k < 4; k++) begin
            send_beat(w[16*k +: 8], w[16*k+8 +: 8]);
        end
    endtask

    task automatic yumi();
        core_yumi_i = 1'b1;
        tick();
        core_yumi_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        io_valid_i = 1'b0;
        core_yumi_i = 1'b0;
        io_data_ch0_i = '0;
        io_data_ch1_i = '0;
        tick();
        tick();
        rst = 1'b0;
        total++; if (io_token_o !== 1'b0) begin bad++; $display("FAIL reset_token: got %b want 0", io_token_o); end
        total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", core_valid_o); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
        total++; if (dut.count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", dut.count); end
    endtask

    task automatic test_single_word();
        do_reset();
        send_beat(8'h01, 8'h02);
        send_beat(8'h03, 8'h04);
        send_beat(8'h05, 8'h06);
        total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %b want 0", core_valid_o); end
        send_beat(8'h07, 8'h08);
        total++; if (core_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", core_valid_o); end
        total++; if (core_data_o !== 64'h0807_0605_0403_0201) begin bad++; $display("FAIL single_data: got %h want 0807060504030201", core_data_o); end
        yumi();
        total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL single_after_pop: got %b want 0", core_valid_o); end
    endtask

    task automatic test_gapped();
        do_reset();
        send_beat(8'h01, 8'h02);
        send_beat(8'h03, 8'h04);
        tick(); tick(); tick();
        total++; if (dut.beat_ctr !== 2'd2) begin bad++; $display("FAIL gap_beat_ctr: got %0d want 2", dut.beat_ctr); end
        send_beat(8'h05, 8'h06);
        total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL gap_early_valid: got %b want 0", core_valid_o); end
        send_beat(8'h07, 8'h08);
        total++; if (core_valid_o !== 1'b1) begin bad++; $display("FAIL gap_valid: got %b want 1", core_valid_o); end
        total++; if (core_data_o !== 64'h0807_0605_0403_0201) begin bad++; $display("FAIL gap_data: got %h want 0807060504030201", core_data_o); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 4; i++) send_word(wv[i]);
        total++; if (dut.count !== 3'd4) begin bad++; $display("FAIL fill_count: got %0d want 4", dut.count); end
        total++; if (core_valid_o !== 1'b1) begin bad++; $display("FAIL fill_valid: got %b want 1", core_valid_o); end
        for (int i = 0; i < 4; i++) begin
            total++; if (core_data_o !== wv[i]) begin bad++; $display("FAIL drain_data%0d: got %h want %h", i, core_data_o, wv[i]); end
            yumi();
            total++; if (io_token_o !== (i == 3)) begin bad++; $display("FAIL drain_token%0d: got %b want %b", i, io_token_o, (i == 3)); end
        end
        total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL drain_empty: got %b want 0", core_valid_o); end
        tick();
        total++; if (io_token_o !== 1'b1) begin bad++; $display("FAIL drain_token_hold: got %b want 1", io_token_o); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 4; i++) send_word(wv[i]);
        for (int k = 0; k < 3; k++) send_beat(wv[4][16*k +: 8], wv[4][16*k+8 +: 8]);
        io_valid_i    = 1'b1;
        io_data_ch0_i = wv[4][55:48];
        io_data_ch1_i = wv[4][63:56];
        core_yumi_i   = 1'b1;
        tick();
        io_valid_i  = 1'b0;
        core_yumi_i = 1'b0;
        total++; if (dut.count !== 3'd4) begin bad++; $display("FAIL pp_count: got %0d want 4", dut.count); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL pp_overflow: got %b want 0", overflow_o); end
        for (int i = 1; i < 5; i++) begin
            total++; if (core_data_o !== wv[i]) begin bad++; $display("FAIL pp_data%0d: got %h want %h", i, core_data_o, wv[i]); end
            yumi();
        end
        total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL pp_empty: got %b want 0", core_valid_o); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) send_word(wv[i]);
        send_word(wv[4]);
        total++; if (dut.count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", dut.count); end
        total++; if (overflow_o !== OVF_EXP) begin bad++; $display("FAIL ovf_flag: got %b want %b", overflow_o, OVF_EXP); end
        for (int i = 0; i < 4; i++) begin
            total++; if (core_data_o !== wv[i]) begin bad++; $display("FAIL ovf_data%0d: got %h want %h", i, core_data_o, wv[i]); end
            yumi();
        end
        total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %b want 0", core_valid_o); end
        total++; if (overflow_o !== OVF_EXP) begin bad++; $display("FAIL ovf_sticky: got %b want %b", overflow_o, OVF_EXP); end
    endtask

    task automatic test_stray_yumi();
        do_reset();
        yumi();
        yumi();
        yumi();
        yumi();
        total++; if (dut.count !== 3'd0) begin bad++; $display("FAIL stray_count: got %0d want 0", dut.count); end
        total++; if (dut.tok_ctr !== 2'd0) begin bad++; $display("FAIL stray_tok_ctr: got %0d want 0", dut.tok_ctr); end
        total++; if (io_token_o !== 1'b0) begin bad++; $display("FAIL stray_token: got %b want 0", io_token_o); end
        send_word(wv[2]);
        total++; if (core_data_o !== wv[2]) begin bad++; $display("FAIL stray_data: got %h want %h", core_data_o, wv[2]); end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_word(wv[i]);
            yumi();
        end
        send_word(wv[0]);
        yumi();
        total++; if (io_token_o !== 1'b1 || dut.tok_ctr !== 2'd1) begin bad++; $display("FAIL mid_pre_token: got %b/%0d want 1/1", io_token_o, dut.tok_ctr); end
        send_word(wv[1]);
        send_beat(8'hAA, 8'hBB);
        send_beat(8'hCC, 8'hDD);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (io_token_o !== 1'b0) begin bad++; $display("FAIL mid_token: got %b want 0", io_token_o); end
        total++; if (dut.tok_ctr !== 2'd0) begin bad++; $display("FAIL mid_tok_ctr: got %0d want 0", dut.tok_ctr); end
        total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", core_valid_o); end
        send_beat(8'h11, 8'h12);
        send_beat(8'h13, 8'h14);
        send_beat(8'h15, 8'h16);
        send_beat(8'h17, 8'h18);
        total++; if (core_data_o !== 64'h1817_1615_1413_1211) begin bad++; $display("FAIL mid_data: got %h want 1817161514131211", core_data_o); end
        yumi();
        total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL mid_only_one: got %b want 0", core_valid_o); end
        total++; if (dut.tok_ctr !== 2'd1) begin bad++; $display("FAIL mid_tok_restart: got %0d want 1", dut.tok_ctr); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) begin
                io_valid_i    = 1'b1;
                io_data_ch0_i = wv[i][16*k +: 8];
                io_data_ch1_i = wv[i][16*k+8 +: 8];
                tick();
            end
            total++; if (dut.count !== 3'(i + 1)) begin bad++; $display("FAIL b2b_count%0d: got %0d want %0d", i, dut.count, i + 1); end
        end
        io_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (core_data_o !== wv[i]) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", i, core_data_o, wv[i]); end
            yumi();
        end
    endtask

    initial begin
        wv[0] = 64'h0807_0605_0403_0201;
        wv[1] = 64'hDEAD_BEEF_CAFE_F00D;
        wv[2] = 64'h1234_5678_9ABC_DEF0;
        wv[3] = 64'hA5A5_5A5A_0F0F_F0F0;
        wv[4] = 64'h7766_5544_3322_1100;
        test_reset();
        test_single_word();
        test_gapped();
        test_fill_drain();
        test_full_push_pop();
        test_overflow();
`ifndef LINK_DS_OVERFLOW_CHECK_EN
        test_stray_yumi();
`endif
        test_reset_mid_word();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
